vote_tally_scheduler: RTL
=========================

VOTE_TALLY_SCHEDULER -- requirements
Module: vote_tally_scheduler

Interface
REQ-001 Parameter N_REQ, default 4: number of vote requesters (2..16).
REQ-002 Parameter MAX_COUNT, default 256: per-requester tally modulus; CW = $clog2(MAX_COUNT).
REQ-003 Parameter TOTAL_W, default 16: width of the total-vote counter.
REQ-004 clk_in  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n_in  input  1  asynchronous, active-low reset.
REQ-006 req_in  input  N_REQ  per-requester level vote request, held until acknowledged.
REQ-007 clear_in  input  1  single-cycle request to zero all tallies.
REQ-008 ack_out  output  N_REQ  one-hot, one-cycle acknowledge of the granted vote.
REQ-009 tally_out  output  N_REQ*CW  packed tallies; requester i at bits [i*CW +: CW].
REQ-010 total_out  output  TOTAL_W  total accepted votes since reset/clear, modulo 2^TOTAL_W.
REQ-011 wrap_out  output  N_REQ  sticky per-requester flag: tally wrapped at least once.
REQ-012 busy_out  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 FSM states SHALL be IDLE, ACK, CLEAR; all outputs registered.
REQ-014 IDLE, clear_in=1: go to CLEAR, load index 0, zero total_out this edge; no grant this cycle, even if req_in non-zero.
REQ-015 IDLE, clear_in=0, req_in!=0: select one winner w, tally[w] += 1, total_out += 1, ack_out = one-hot(w) next cycle, go to ACK.
REQ-016 IDLE, clear_in=0, req_in=0: remain IDLE; ack_out = 0.
REQ-017 ACK: lasts exactly one cycle with ack_out high; no grant issued; return to IDLE. Requesters drop req_in in the ack cycle; a req still high in the following IDLE cycle is a new vote.
REQ-018 Latency: req_in high in IDLE cycle t -> ack_out and updated tally visible in cycle t+1; peak throughput one vote per 2 cycles.
REQ-019 Tally wrap: tally[i] at MAX_COUNT-1 increments to 0 and sets wrap_out[i]; wrap_out[i] clears only on reset or CLEAR.
REQ-020 total_out wraps modulo 2^TOTAL_W silently.
REQ-021 CLEAR: zero tally[index] and wrap_out[index] each cycle, index 0..N_REQ-1, then return to IDLE (N_REQ cycles in CLEAR).
REQ-022 clear_in sampled only in IDLE; pulses in ACK or CLEAR ignored.
REQ-023 req_in ignored during ACK and CLEAR; pending levels are served on return to IDLE.
REQ-024 Arbitration pointer updates to w on every grant.

Reset
REQ-025 rst_n_in low: FSM=IDLE, tallies=0, total_out=0, wrap_out=0, ack_out=0, busy_out=0, pointer=N_REQ-1, immediately and independent of clk_in.
REQ-026 Reset asserted mid-ACK or mid-CLEAR SHALL abort the operation; no partial ack pulse after release.
REQ-027 First rising edge after rst_n_in deasserts behaves as IDLE.

Configuration
REQ-028 Macro VOTE_RR_ARB_EN defined: round-robin; winner is the first asserted req at index pointer+1, pointer+2, ... modulo N_REQ.
REQ-029 VOTE_RR_ARB_EN undefined: fixed priority, lowest asserted index wins; pointer logic absent; all other behaviour identical.

Verification
REQ-030 Reset, req_in=4'b0001 for one cycle -> ack_out=4'b0001 next cycle, tally0=1, total_out=1, busy_out high for 1 cycle.
REQ-031 RR build, req_in=4'b1111 held -> acks 0001,0010,0100,1000,0001 on alternate cycles; fixed build -> ack 0001 every grant.
REQ-032 255 single votes on requester 2 then one more (MAX_COUNT=256) -> tally2 0, wrap_out=4'b0100, total_out=256.
REQ-033 clear_in and req_in=4'b0010 in same IDLE cycle -> no ack; 4 CLEAR cycles zero tallies/wrap_out, total_out=0; then ack_out=4'b0010, tally1=1.
REQ-034 rst_n_in low during cycle 2 of CLEAR with non-zero tallies -> all outputs 0 asynchronously; FSM IDLE after release.

Source files
------------

// File: rtl/vote_tally_scheduler.sv
// vote_tally_scheduler
//   Arbitrates level vote requests from N_REQ requesters, acknowledging one
//   vote per grant, and keeps a per-requester modulo tally, a sticky wrap
//   flag per requester, and a running total of accepted votes.
//
//   Optional feature macro: VOTE_RR_ARB_EN
//     defined   -> round-robin arbitration, starting after the last winner
//     undefined -> fixed priority, lowest asserted index wins
//
//   Ports
//     clk_in     : clock, rising edge
//     rst_n_in   : asynchronous active-low reset
//     req_in     : [N_REQ] level vote requests, held until acknowledged
//     clear_in   : single-cycle request to zero tallies, wraps and total
//     ack_out    : [N_REQ] one-hot one-cycle acknowledge of the granted vote
//     tally_out  : [N_REQ*CW] packed tallies, requester i at [i*CW +: CW]
//     total_out  : [TOTAL_W] accepted votes since reset/clear, modulo 2^TOTAL_W
//     wrap_out   : [N_REQ] sticky flag, tally wrapped at least once
//     busy_out   : high whenever the FSM is not in IDLE

// One requester's tally and sticky wrap flag.
module vote_tally_lane #(
  parameter int MAX_COUNT = 256,
  parameter int CW        = $clog2(MAX_COUNT)
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic          inc_in,
  input  logic          clr_in,
  output logic [CW-1:0] tally_out,
  output logic          wrap_out
);
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tally_out <= '0;
      wrap_out  <= 1'b0;
    end else if (clr_in) begin
      tally_out <= '0;
      wrap_out  <= 1'b0;
    end else if (inc_in) begin
      // Explicit compare so non-power-of-two moduli wrap correctly.
      if (tally_out == CW'(MAX_COUNT - 1)) begin
        tally_out <= '0;
        wrap_out  <= 1'b1;
      end else begin
        tally_out <= tally_out + 1'b1;
      end
    end
  end
endmodule

module vote_tally_scheduler #(
  parameter int N_REQ     = 4,
  parameter int MAX_COUNT = 256,
  parameter int TOTAL_W   = 16,
  localparam int CW       = $clog2(MAX_COUNT)
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [N_REQ-1:0]      req_in,
  input  logic                  clear_in,
  output logic [N_REQ-1:0]      ack_out,
  output logic [N_REQ*CW-1:0]   tally_out,
  output logic [TOTAL_W-1:0]    total_out,
  output logic [N_REQ-1:0]      wrap_out,
  output logic                  busy_out
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_CLEAR} state_t;

  state_t           state;
  logic [PW-1:0]    idx;
  logic [PW-1:0]    win;
  logic             win_vld;
  logic [N_REQ-1:0] win_oh;
  logic [N_REQ-1:0] lane_inc;
  logic [N_REQ-1:0] lane_clr;

  // ---------------------------------------------------------------- arbiter
`ifdef VOTE_RR_ARB_EN
  logic [PW-1:0] ptr;
  logic [PW:0]   cand;

  // Scan ptr+1, ptr+2, ... modulo N_REQ; first asserted request wins.
  // cand never exceeds 2*N_REQ-1, so one conditional subtract reduces it.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    cand    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr} + (PW+1)'(k + 1);
      if (cand >= (PW+1)'(N_REQ)) cand = cand - (PW+1)'(N_REQ);
      if (!win_vld && req_in[cand[PW-1:0]]) begin
        win     = cand[PW-1:0];
        win_vld = 1'b1;
      end
    end
  end
`else
  always_comb begin
    win     = '0;
    win_vld = |req_in;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (req_in[k]) win = PW'(k);
  end
`endif

  assign win_oh = N_REQ'(1) << win;

  // Lane strobes are decoded from registered state, so tallies land on the
  // same edge as the ack.
  assign lane_inc = (state == S_IDLE && !clear_in && win_vld) ? win_oh : '0;
  assign lane_clr = (state == S_CLEAR) ? (N_REQ'(1) << idx) : '0;

  // -------------------------------------------------------------------- FSM
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state     <= S_IDLE;
      idx       <= '0;
      total_out <= '0;
      ack_out   <= '0;
      busy_out  <= 1'b0;
`ifdef VOTE_RR_ARB_EN
      ptr       <= PW'(N_REQ - 1);
`endif
    end else begin
      case (state)
        S_IDLE: begin
          ack_out <= '0;
          if (clear_in) begin
            // Clear wins over any pending vote; total zeroes immediately,
            // tallies are swept one per cycle in CLEAR.
            state     <= S_CLEAR;
            idx       <= '0;
            total_out <= '0;
            busy_out  <= 1'b1;
          end else if (win_vld) begin
            state     <= S_ACK;
            ack_out   <= win_oh;
            total_out <= total_out + TOTAL_W'(1);
            busy_out  <= 1'b1;
`ifdef VOTE_RR_ARB_EN
            ptr       <= win;
`endif
          end
        end
        S_ACK: begin
          ack_out  <= '0;
          state    <= S_IDLE;
          busy_out <= 1'b0;
        end
        S_CLEAR: begin
          if (idx == PW'(N_REQ - 1)) begin
            state    <= S_IDLE;
            busy_out <= 1'b0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          ack_out  <= '0;
          busy_out <= 1'b0;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------ lanes
  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    vote_tally_lane #(.MAX_COUNT(MAX_COUNT), .CW(CW)) u_lane (
      .clk_in    (clk_in),
      .rst_n_in  (rst_n_in),
      .inc_in    (lane_inc[i]),
      .clr_in    (lane_clr[i]),
      .tally_out (tally_out[i*CW +: CW]),
      .wrap_out  (wrap_out[i])
    );
  end
endmodule
